// File: rtl/lvds_word_aligner.sv
// Single-lane SDR deserializer and word aligner for the LVDS receive path.
// Hunts for SYNC_PATTERN on any bit offset, confirms it over LOCK_COUNT
// consecutive word boundaries, then emits aligned words until sync words stop.
//
// state  | meaning
// HUNT   | comparing the sliding window against the sync word on every bit
// VERIFY | sync seen once; confirming it recurs on each word boundary
// LOCKED | aligned; a word is emitted on each boundary, sync spacing watched
module lvds_word_aligner #(
  parameter int                    WORD_WIDTH    = 10,
  parameter logic [WORD_WIDTH-1:0] SYNC_PATTERN  = 10'h0FA,
  parameter int                    LOCK_COUNT    = 4,
  parameter int                    SYNC_INTERVAL = 256
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  serial_in,
  input  logic                  enable,
  input  logic                  resync,
  output logic [WORD_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  sync_detect,
  output logic                  locked
);

  localparam int CW = $clog2(WORD_WIDTH);
  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int IW = $clog2(SYNC_INTERVAL + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WORD_WIDTH - 1);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  state_t                state_q, state_d;
  logic [WORD_WIDTH-2:0] shift_q;
  logic [CW-1:0]         fill_q;
  logic [CW-1:0]         bit_q, bit_d;
  logic [MW-1:0]         match_q, match_d, match_inc;
  logic [IW-1:0]         interval_q, interval_d, interval_inc;
  logic [WORD_WIDTH-1:0] window;
  logic                  win_valid;
  logic                  boundary;
  logic                  is_sync;
  logic                  emit;

  // The current sample completes the window, so a word is seen the cycle its last bit arrives.
  assign window       = {shift_q, serial_in};
  assign win_valid    = (fill_q == LAST_BIT);
  assign boundary     = (bit_q == LAST_BIT);
  assign is_sync      = (window == SYNC_PATTERN);
  assign match_inc    = match_q + MW'(1);
  assign interval_inc = interval_q + IW'(1);

  // Next-state, counter updates and the emit decision for this bit.
  always_comb begin
    state_d    = state_q;
    match_d    = match_q;
    interval_d = interval_q;
    bit_d      = boundary ? '0 : bit_q + CW'(1);
    emit       = 1'b0;
    if (resync) begin
      state_d    = HUNT;
      match_d    = '0;
      interval_d = '0;
      bit_d      = '0;
    end else begin
      case (state_q)
        HUNT: begin
          if (win_valid && is_sync) begin
            bit_d   = '0;
            match_d = MW'(1);
            state_d = (LOCK_COUNT == 1) ? LOCKED : VERIFY;
          end
        end
        VERIFY: begin
          if (boundary) begin
            if (is_sync) begin
              match_d = match_inc;
              if (match_inc == MW'(LOCK_COUNT)) state_d = LOCKED;
            end else begin
              // Deliberately no re-detection here: hunting restarts on the next bit.
              state_d = HUNT;
              match_d = '0;
            end
          end
        end
        LOCKED: begin
          if (boundary) begin
            emit = 1'b1;
            if (is_sync) begin
              interval_d = '0;
            end else if (interval_inc == IW'(SYNC_INTERVAL)) begin
              state_d    = HUNT;
              interval_d = '0;
              match_d    = '0;
            end else begin
              interval_d = interval_inc;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // State and alignment counters; everything holds while enable is low.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= HUNT;
      bit_q      <= '0;
      match_q    <= '0;
      interval_q <= '0;
      locked     <= 1'b0;
    end else if (enable) begin
      state_q    <= state_d;
      bit_q      <= bit_d;
      match_q    <= match_d;
      interval_q <= interval_d;
      locked     <= (state_d == LOCKED);
    end
  end

  // Bit history; resync keeps it so hunting can resume without refilling.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shift_q <= '0;
      fill_q  <= '0;
    end else if (enable) begin
      shift_q <= window[WORD_WIDTH-2:0];
      if (fill_q != LAST_BIT) fill_q <= fill_q + CW'(1);
    end
  end

  // Registered word output with single-cycle strobes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_out    <= '0;
      data_valid  <= 1'b0;
      sync_detect <= 1'b0;
    end else begin
      data_valid  <= 1'b0;
      sync_detect <= 1'b0;
      if (enable && emit) begin
        data_out    <= window;
        data_valid  <= 1'b1;
        sync_detect <= is_sync;
      end
    end
  end

endmodule
